// File: rtl/updi_prog_sequencer.sv
// UPDI programming sequencer: break, unlock, erase, then write/verify
// every ROM block with per-step retry and response timeout.
module updi_prog_sequencer #(
  parameter int ADDR_BITS   = 16,
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT_CLK = 65536,
  parameter int CHECK_DEVID = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 verify_en,
  input  logic [7:0]           dev_id_expected,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           err_code,
  output logic                 brk_start,
  input  logic                 brk_busy,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [2:0]           cmd_op,
  output logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 rsp_valid,
  input  logic                 rsp_ok,
  input  logic [7:0]           rsp_data,
  output logic                 rom_rewind,
  output logic                 rom_next,
  input  logic                 rom_valid,
  input  logic [ADDR_BITS-1:0] rom_addr,
  input  logic                 rom_last
);

  localparam int TW = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CLK - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_BREAK, S_STATUS, S_ERASE,
    S_NVMPROG, S_RSTCHIP, S_DEVID, S_PROG_REQ,
    S_PROG_CMD, S_VER_REQ, S_VER_CMD, S_FAIL
  } state_t;

  state_t st, st_n;
  logic pend, pend_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] retry, retry_n;
  logic brk_seen, brk_seen_n;
  logic reqd, reqd_n;
  logic [ADDR_BITS-1:0] la, la_n;
  logic ll, ll_n;
  logic ver_q, ver_n;
  logic [7:0] id_q, id_n;
  logic [2:0] ec, ec_n;
  logic done_q, done_n;
  logic brk_q, brk_n;
  logic rew_q, rew_n;

  logic cmd_st, req_st, ok_hit, nack, tmo;

  always_comb begin
    cmd_st = (st == S_STATUS) || (st == S_ERASE)
          || (st == S_NVMPROG) || (st == S_RSTCHIP)
          || (st == S_DEVID) || (st == S_PROG_CMD)
          || (st == S_VER_CMD);
    req_st = (st == S_PROG_REQ) || (st == S_VER_REQ);
    ok_hit = pend && rsp_valid && rsp_ok;
    nack   = pend && rsp_valid && !rsp_ok;
    tmo    = pend && !rsp_valid && (tcnt == TLIM);
  end

  always_comb begin
    cmd_op = 3'd0;
    unique case (1'b1)
      st == S_ERASE:    cmd_op = 3'd1;
      st == S_NVMPROG:  cmd_op = 3'd2;
      st == S_RSTCHIP:  cmd_op = 3'd3;
      st == S_DEVID:    cmd_op = 3'd4;
      st == S_PROG_CMD: cmd_op = 3'd5;
      st == S_VER_CMD:  cmd_op = 3'd6;
      default:          cmd_op = 3'd0;
    endcase
  end

  assign busy       = (st != S_IDLE) && (st != S_FAIL);
  assign error      = (st == S_FAIL);
  assign done       = done_q;
  assign err_code   = ec;
  assign brk_start  = brk_q;
  assign rom_rewind = rew_q;
  assign rom_next   = req_st && !reqd && !rew_q;
  assign cmd_valid  = cmd_st && !pend;
  assign cmd_addr   = (st == S_PROG_CMD || st == S_VER_CMD)
                    ? la : '0;

  always_comb begin
    st_n       = st;
    pend_n     = pend;
    tcnt_n     = tcnt;
    retry_n    = retry;
    brk_seen_n = brk_seen;
    reqd_n     = reqd;
    la_n       = la;
    ll_n       = ll;
    ver_n      = ver_q;
    id_n       = id_q;
    ec_n       = ec;
    done_n     = 1'b0;
    brk_n      = 1'b0;
    rew_n      = 1'b0;

    // shared issue / wait / retry handling for all command steps
    if (cmd_st) begin
      if (!pend) begin
        if (cmd_ready) begin
          pend_n = 1'b1;
          tcnt_n = '0;
        end
      end else if (nack || tmo) begin
        pend_n = 1'b0;
        tcnt_n = '0;
        if (retry < RMAX) begin
          retry_n = retry + 4'd1;
        end else begin
          st_n = S_FAIL;
          ec_n = nack ? 3'd2 : 3'd1;
        end
      end else if (!rsp_valid) begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    if (ok_hit) begin
      pend_n  = 1'b0;
      tcnt_n  = '0;
      retry_n = '0;
    end

    case (st)
      S_IDLE: begin
        if (start && !abort) begin
          st_n       = S_BREAK;
          brk_n      = 1'b1;
          ec_n       = 3'd0;
          ver_n      = verify_en;
          id_n       = dev_id_expected;
          brk_seen_n = 1'b0;
          pend_n     = 1'b0;
          retry_n    = '0;
          tcnt_n     = '0;
          reqd_n     = 1'b0;
        end
      end
      S_BREAK: begin
        if (brk_busy) brk_seen_n = 1'b1;
        else if (brk_seen) st_n = S_STATUS;
      end
      S_STATUS:  if (ok_hit) st_n = S_ERASE;
      S_ERASE:   if (ok_hit) st_n = S_NVMPROG;
      S_NVMPROG: if (ok_hit) st_n = S_RSTCHIP;
      S_RSTCHIP: if (ok_hit) st_n = S_DEVID;
      S_DEVID: begin
        if (ok_hit) begin
          if (CHECK_DEVID != 0 && rsp_data != id_q) begin
            st_n = S_FAIL;
            ec_n = 3'd3;
          end else begin
            st_n = S_PROG_REQ;
          end
        end
      end
      S_PROG_REQ, S_VER_REQ: begin
        if (!reqd) begin
          if (!rew_q) reqd_n = 1'b1;
        end else if (rom_valid) begin
          la_n   = rom_addr;
          ll_n   = rom_last;
          reqd_n = 1'b0;
          st_n   = (st == S_PROG_REQ) ? S_PROG_CMD : S_VER_CMD;
        end
      end
      S_PROG_CMD: begin
        if (ok_hit) begin
          if (!ll) begin
            st_n = S_PROG_REQ;
          end else if (ver_q) begin
            st_n  = S_VER_REQ;
            rew_n = 1'b1;
          end else begin
            st_n   = S_IDLE;
            done_n = 1'b1;
          end
        end
      end
      S_VER_CMD: begin
        if (ok_hit) begin
          if (ll) begin
            st_n   = S_IDLE;
            done_n = 1'b1;
          end else begin
            st_n = S_VER_REQ;
          end
        end
      end
      S_FAIL: begin
        st_n    = S_IDLE;
        pend_n  = 1'b0;
        retry_n = '0;
        tcnt_n  = '0;
        reqd_n  = 1'b0;
      end
      default: st_n = S_IDLE;
    endcase

    // abort pre-empts everything, including a pending handshake
    if (abort && st != S_IDLE && st != S_FAIL) begin
      st_n   = S_FAIL;
      ec_n   = 3'd4;
      pend_n = 1'b0;
      done_n = 1'b0;
      rew_n  = 1'b0;
      brk_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      pend     <= 1'b0;
      tcnt     <= '0;
      retry    <= '0;
      brk_seen <= 1'b0;
      reqd     <= 1'b0;
      la       <= '0;
      ll       <= 1'b0;
      ver_q    <= 1'b0;
      id_q     <= '0;
      ec       <= '0;
      done_q   <= 1'b0;
      brk_q    <= 1'b0;
      rew_q    <= 1'b0;
    end else begin
      st       <= st_n;
      pend     <= pend_n;
      tcnt     <= tcnt_n;
      retry    <= retry_n;
      brk_seen <= brk_seen_n;
      reqd     <= reqd_n;
      la       <= la_n;
      ll       <= ll_n;
      ver_q    <= ver_n;
      id_q     <= id_n;
      ec       <= ec_n;
      done_q   <= done_n;
      brk_q    <= brk_n;
      rew_q    <= rew_n;
    end
  end

endmodule

// File: tb/tb_updi_prog_sequencer.sv
// Directed bench for updi_prog_sequencer with a small UPDI/ROM model.
module tb_updi_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        verify_en = 1'b0;
  logic [7:0]  dev_id_expected = 8'h00;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic        brk_start;
  logic        brk_busy;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic        rsp_valid = 1'b0;
  logic        rsp_ok = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        rom_rewind, rom_next;
  logic        rom_valid = 1'b0;
  logic [15:0] rom_addr = 16'h0;
  logic        rom_last = 1'b0;

  updi_prog_sequencer #(
    .ADDR_BITS(16), .MAX_RETRIES(2),
    .TIMEOUT_CLK(16), .CHECK_DEVID(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .verify_en(verify_en),
    .dev_id_expected(dev_id_expected),
    .busy(busy), .done(done), .error(error),
    .err_code(err_code), .brk_start(brk_start),
    .brk_busy(brk_busy), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .rsp_valid(rsp_valid),
    .rsp_ok(rsp_ok), .rsp_data(rsp_data),
    .rom_rewind(rom_rewind), .rom_next(rom_next),
    .rom_valid(rom_valid), .rom_addr(rom_addr),
    .rom_last(rom_last)
  );

  always #5 clk = ~clk;

  // model configuration, written only by the stimulus process
  int         nack_n = 0;
  int         silent_op = 7;
  logic [7:0] dev_data = 8'h1E;
  logic       hold_wb = 1'b0;

  // model state, written only by the model process
  int cyc = 0;
  int rdly = 0;
  int bcnt = 0;
  int st_cnt = 0;
  int ptr = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rn_cnt = 0;
  int op_q[$];
  logic [15:0] ad_q[$];
  int cyc_q[$];

  assign brk_busy  = (bcnt != 0);
  assign cmd_ready = !(hold_wb && cmd_op == 3'd5);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rsp_valid <= 1'b0;
    rom_valid <= 1'b0;
    if (rst) bcnt <= 0;
    else if (brk_start) bcnt <= 3;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    if (rdly != 0) begin
      rdly <= rdly - 1;
      if (rdly == 1) rsp_valid <= 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      if (int'(cmd_op) != silent_op) rdly <= 2;
      rsp_ok   <= !(cmd_op == 3'd0 && st_cnt < nack_n);
      rsp_data <= dev_data;
    end
    if (rst || brk_start) begin
      op_q.delete();
      ad_q.delete();
      cyc_q.delete();
      st_cnt   <= 0;
      ptr      <= 0;
      done_cnt <= 0;
      err_cnt  <= 0;
      rn_cnt   <= 0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (error) err_cnt <= err_cnt + 1;
      if (rom_next) rn_cnt <= rn_cnt + 1;
      if (rom_rewind) begin
        ptr <= 0;
      end else if (rom_next) begin
        rom_valid <= 1'b1;
        rom_addr  <= 16'h8000 + 16'(ptr * 64);
        rom_last  <= (ptr == 2);
        ptr       <= ptr + 1;
      end
      if (cmd_valid && cmd_ready) begin
        op_q.push_back(int'(cmd_op));
        ad_q.push_back(cmd_addr);
        cyc_q.push_back(cyc);
        if (cmd_op == 3'd0) st_cnt <= st_cnt + 1;
      end
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_op(input int op);
    int n = 0;
    foreach (op_q[i]) if (op_q[i] == op) n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input logic ver,
                           input logic [7:0] id);
    @(negedge clk);
    verify_en = ver;
    dev_id_expected = id;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_cmd(input string tag,
                          input logic [2:0] op);
    int n = 0;
    while (!(cmd_valid && cmd_op == op) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 500), 32'd1);
  endtask

  int exp_op[11] = '{0, 1, 2, 3, 4, 5, 5, 5, 6, 6, 6};
  int exp_ad[11] = '{0, 0, 0, 0, 0,
                     'h8000, 'h8040, 'h8080,
                     'h8000, 'h8040, 'h8080};

  initial begin
    int j1, j2, any, late;

    // reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_brk_start", 32'(brk_start), 0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_brk", 32'(brk_start), 0);

    // nominal run with verify
    start_run(1'b1, 8'h1E);
    chk("nom_brk_start", 32'(brk_start), 1);
    chk("nom_busy", 32'(busy), 1);
    wait_end("nom_end", 2000);
    chk("nom_done_cnt", 32'(done_cnt), 1);
    chk("nom_err_cnt", 32'(err_cnt), 0);
    chk("nom_err_code", 32'(err_code), 0);
    chk("nom_ncmd", 32'(op_q.size()), 11);
    for (int i = 0; i < 11 && i < op_q.size(); i++) begin
      chk($sformatf("nom_op%0d", i), 32'(op_q[i]), 32'(exp_op[i]));
      chk($sformatf("nom_ad%0d", i), 32'(ad_q[i]), 32'(exp_ad[i]));
    end

    // two NACKs on STATUS_READ: third attempt succeeds
    nack_n = 2;
    start_run(1'b1, 8'h1E);
    wait_end("r2_end", 2000);
    chk("r2_status_cnt", 32'(count_op(0)), 3);
    chk("r2_done_cnt", 32'(done_cnt), 1);
    chk("r2_err_code", 32'(err_code), 0);

    // three NACKs: retries exhausted
    nack_n = 3;
    start_run(1'b1, 8'h1E);
    wait_end("r3_end", 2000);
    chk("r3_err_cnt", 32'(err_cnt), 1);
    chk("r3_done_cnt", 32'(done_cnt), 0);
    chk("r3_err_code", 32'(err_code), 2);
    chk("r3_no_erase", 32'(count_op(1)), 0);
    chk("r3_status_cnt", 32'(count_op(0)), 3);
    nack_n = 0;

    // ERASE never answered: timeout on every attempt
    silent_op = 1;
    start_run(1'b1, 8'h1E);
    wait_end("to_end", 2000);
    chk("to_erase_cnt", 32'(count_op(1)), 3);
    chk("to_err_code", 32'(err_code), 1);
    chk("to_err_cnt", 32'(err_cnt), 1);
    j1 = -1;
    j2 = -1;
    foreach (op_q[i]) begin
      if (op_q[i] == 1 && j1 < 0) j1 = i;
      else if (op_q[i] == 1 && j2 < 0) j2 = i;
    end
    if (j1 >= 0 && j2 >= 0)
      chk("to_retry_gap", 32'(cyc_q[j2] - cyc_q[j1]), 17);
    else
      chk("to_retry_found", 32'(j2), 32'(1));
    silent_op = 7;

    // device-ID mismatch: no retry, no ROM access
    dev_data = 8'h95;
    start_run(1'b1, 8'h1E);
    wait_end("id_end", 2000);
    chk("id_err_code", 32'(err_code), 3);
    chk("id_devid_cnt", 32'(count_op(4)), 1);
    chk("id_rom_next", 32'(rn_cnt), 0);
    dev_data = 8'h1E;

    // abort while WRITE_BLOCK is stalled on cmd_ready
    hold_wb = 1'b1;
    start_run(1'b1, 8'h1E);
    wait_cmd("ab_wait", 3'd5);
    abort = 1'b1;
    @(negedge clk);
    chk("ab_cmd_valid", 32'(cmd_valid), 0);
    chk("ab_err_code", 32'(err_code), 4);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_error", 32'(error), 1);
    abort = 1'b0;
    hold_wb = 1'b0;
    @(negedge clk);
    chk("ab_err_cnt", 32'(err_cnt), 1);
    start_run(1'b0, 8'h1E);
    wait_end("ab_rerun_end", 2000);
    chk("ab_rerun_done", 32'(done_cnt), 1);
    chk("ab_rerun_code", 32'(err_code), 0);
    chk("ab_rerun_ncmd", 32'(op_q.size()), 8);

    // reset during VER_CMD, then a late response arrives
    start_run(1'b1, 8'h1E);
    wait_cmd("rv_wait", 3'd6);
    rst = 1'b1;
    @(negedge clk);
    chk("rv_busy", 32'(busy), 0);
    chk("rv_cmd_valid", 32'(cmd_valid), 0);
    chk("rv_brk", 32'(brk_start), 0);
    chk("rv_rom_next", 32'(rom_next), 0);
    chk("rv_rom_rewind", 32'(rom_rewind), 0);
    chk("rv_err_code", 32'(err_code), 0);
    chk("rv_done_err", 32'({done, error}), 0);
    rst = 1'b0;
    any = 0;
    late = 0;
    repeat (5) begin
      @(negedge clk);
      any |= int'(busy | cmd_valid | done | error
                | brk_start | rom_next);
      late |= int'(rsp_valid);
    end
    chk("rv_late_rsp_seen", 32'(late), 1);
    chk("rv_quiet", 32'(any), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/updi_prog_sequencer.md
UPDI_PROG_SEQUENCER -- requirements
Module: updi_prog_sequencer

Interface
REQ-001 Parameter ADDR_BITS, 16, target address width (16 or 24); cmd_addr and rom_addr width.
REQ-002 Parameter MAX_RETRIES, 3, retries per step after the first attempt fails (0..15).
REQ-003 Parameter TIMEOUT_CLK, 65536, cycles from command acceptance to response before the attempt fails.
REQ-004 Parameter CHECK_DEVID, 1, when 1 the device ID is compared against dev_id_expected.
REQ-005 clk  in  1  sole clock; one clock domain; all logic on the posedge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 start  in  1  one-cycle pulse to begin a programming run; honoured only in IDLE.
REQ-008 abort  in  1  level input; forces the sequence to end.
REQ-009 verify_en  in  1  sampled on start; enables the VERIFY pass.
REQ-010 dev_id_expected  in  8  signature byte, sampled on start.
REQ-011 busy / done / error  out  1 each  run active / pulse on success / pulse on failure.
REQ-012 err_code  out  3  0 none, 1 timeout, 2 NACK after retries, 3 device-ID mismatch, 4 aborted; held until the next start.
REQ-013 brk_start  out  1  double-break start pulse; brk_busy  in  1  double-break in progress.
REQ-014 cmd_valid  out  1, cmd_ready  in  1, cmd_op  out  3, cmd_addr  out  ADDR_BITS  command channel to the UPDI interface.
REQ-015 rsp_valid  in  1, rsp_ok  in  1, rsp_data  in  8  one-cycle response from the UPDI interface.
REQ-016 rom_rewind  out  1, rom_next  out  1, rom_valid  in  1, rom_addr  in  ADDR_BITS, rom_last  in  1  ROM block iterator.

Function
REQ-017 cmd_op encoding: 0 STATUS_READ, 1 KEY_CHIPERASE, 2 KEY_NVMPROG, 3 RESET_CHIP, 4 READ_ID, 5 WRITE_BLOCK, 6 VERIFY_BLOCK.
REQ-018 States: IDLE, BREAK, STATUS, ERASE, NVMPROG, RSTCHIP, DEVID, PROG_REQ, PROG_CMD, VER_REQ, VER_CMD, FAIL.
REQ-019 In IDLE, start causes brk_start to pulse for 1 cycle, busy=1 on the next cycle, err_code to clear to 0, and a transition to BREAK.
REQ-020 BREAK: leave after brk_busy has been seen high and then low; go to STATUS.
REQ-021 Each command state drives cmd_valid=1 with a stable op/addr until cmd_ready; at most one command is outstanding; cmd_addr=0 except in WRITE_BLOCK/VERIFY_BLOCK.
REQ-022 After the command is accepted, a timeout counter (width clog2(TIMEOUT_CLK+1)) starts counting. The step succeeds when rsp_valid&rsp_ok. rsp_valid&!rsp_ok, or the count reaching TIMEOUT_CLK, fails the attempt.
REQ-023 A failed attempt retries the same command if the retry count is below MAX_RETRIES. Otherwise go to FAIL with err_code 1 (timeout) or 2 (NACK), per the last failure cause. The retry count resets on entry to each step.
REQ-024 Step order: STATUS, ERASE, NVMPROG, RSTCHIP, DEVID, PROG_REQ.
REQ-025 DEVID: if CHECK_DEVID=1 and rsp_data != dev_id_expected, go to FAIL with err_code 3; a mismatch is not retried.
REQ-026 PROG_REQ: pulse rom_next for 1 cycle, then wait for rom_valid. Latch rom_addr and rom_last, then go to PROG_CMD, which issues WRITE_BLOCK at the latched address.
REQ-027 After PROG_CMD succeeds: if latched rom_last=0, return to PROG_REQ. If rom_last=1 and verify_en=1, pulse rom_rewind and go to VER_REQ. Otherwise go to IDLE with a done pulse.
REQ-028 VER_REQ/VER_CMD mirror PROG_REQ/PROG_CMD using VERIFY_BLOCK; rom_last success goes to IDLE with done.
REQ-029 FAIL: error pulses for 1 cycle, busy=0, then IDLE.
REQ-030 abort=1 in any non-IDLE state (including mid-handshake) moves to FAIL next cycle with err_code 4. cmd_valid drops in that same transition, and outstanding responses are ignored.
REQ-031 In IDLE, start and abort asserted together: abort wins, start is ignored, and no state change occurs.
REQ-032 start while busy is ignored; rsp_valid with no command outstanding is ignored; rom_valid outside PROG_REQ/VER_REQ is ignored.
REQ-033 done and error are mutually exclusive, and each is exactly 1 cycle per run.

Reset
REQ-034 rst=1 forces on the next edge: state IDLE, busy/done/error/cmd_valid/brk_start/rom_next/rom_rewind=0, err_code=0, counters=0. This applies mid-run regardless of other inputs.

Verification
REQ-035 Nominal run: all rsp_ok=1, rsp_data=0x1E=dev_id_expected, 3 ROM blocks at 0x8000/0x8040/0x8080, verify_en=1. Required: ops 0,1,2,3,4,5,5,5,6,6,6 in order with those addresses, one done pulse, err_code 0.
REQ-036 Retry: MAX_RETRIES=2, first two STATUS_READ responses NACK. Required: 3 STATUS_READ commands and then the run completes. With three NACKs: error pulse, err_code 2, no KEY_CHIPERASE issued.
REQ-037 Timeout: TIMEOUT_CLK=16, no rsp_valid after ERASE is accepted. Required: retry after 16 cycles, FAIL after MAX_RETRIES+1 attempts, err_code 1.
REQ-038 Device-ID mismatch: rsp_data=0x95, expected 0x1E. Required: err_code 3 with no retry, and rom_next never asserted.
REQ-039 Abort while cmd_valid=1 and cmd_ready=0 in PROG_CMD. Required: cmd_valid=0 next cycle, err_code 4, busy low within 2 cycles; a following start completes normally.
REQ-040 rst asserted during VER_CMD. Required: all outputs are at reset values on the next cycle, and a late rsp_valid causes no change.
